udp_rx_parse: RTL and testbench
===============================

# udp_rx_parse

Receive-side counterpart of the UDP transmit builder. It consumes the byte stream from the RMII RX MAC, with preamble, SFD and FCS already stripped, and parses the 42-byte Ethernet + IPv4 + UDP header. It filters the frame against the FPGA's MAC address, IP address and listen port. For an accepted frame it streams only the UDP payload to the echo buffer and latches the sender's addressing for the reply, then raises a one-cycle echo request.

## Interface
Parameters:
- MAX_PAYLOAD, 256: largest accepted UDP payload in bytes. Larger datagrams are dropped.

Ports:
- clk50  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  frame byte from the RX MAC
- rx_valid  in  1  rx_data is valid this cycle
- rx_sof  in  1  with rx_valid, marks the first byte of a frame (destination MAC byte 0)
- rx_eof  in  1  with rx_valid, marks the last byte of a frame
- rx_err  in  1  with rx_eof, the frame is bad (CRC or PHY error)
- out_payload  out  8  UDP payload byte
- out_valid  out  1  out_payload is valid
- out_last  out  1  final payload byte of an accepted datagram
- out_abort  out  1  one-cycle pulse: the payload already forwarded is invalid and must be discarded
- send_echo  out  1  one-cycle pulse, one cycle after out_last
- src_mac  out  48  sender MAC of the last accepted datagram
- src_ip  out  32  sender IP of the last accepted datagram
- src_port  out  16  sender UDP port of the last accepted datagram
- dst_port  out  16  UDP destination port of the last accepted datagram (equals the listen port)
- pkt_count  out  16  number of accepted datagrams, wraps
- drop_count  out  16  number of rejected or aborted frames, wraps

## Operation
- States:
  - S_IDLE: wait for a frame start.
  - S_HDR: parse header bytes 0..41.
  - S_PAY: forward payload.
  - S_DROP: discard bytes until rx_eof.
- Transitions out of S_IDLE:
  - rx_valid && rx_sof goes to S_HDR with hdr_idx=1. Byte 0 is checked in that same cycle.
  - Bytes arriving without rx_sof are ignored.
- Header checks in S_HDR. Any mismatch sets a sticky bad flag, but parsing continues to byte 41.
  - Bytes 0-5: FPGA_MAC or ff:ff:ff:ff:ff:ff.
  - Bytes 12-13: 0x0800.
  - Byte 14: 0x45. IP options are unsupported.
  - Bytes 20-21: (flags & 0x3FFF)==0, i.e. no fragments.
  - Byte 23: 0x11.
  - Bytes 30-33: FPGA_IP.
  - Bytes 36-37: UDP_LISTEN_PORT.
  - Bytes 38-39: udp_len, with 9 <= udp_len <= MAX_PAYLOAD+8.
  - Bytes 16-17: ip_total_len == udp_len+20.
- Fields captured into shadow registers during S_HDR:
  - Bytes 6-11: src MAC.
  - Bytes 26-29: src IP.
  - Bytes 34-35: src port.
- Decision at byte 41:
  - If no bad flag: shadow values are copied to src_mac/src_ip/src_port/dst_port, pay_rem = udp_len-8 (16-bit), and the state goes to S_PAY.
  - Otherwise drop_count increments and the state goes to S_DROP. If the same byte carries rx_eof, the state goes to S_IDLE instead.
- S_PAY:
  - Each valid byte is forwarded and pay_rem decrements.
  - On the byte where pay_rem==1, out_last is set, pkt_count increments, send_echo is pulsed on the next cycle, and the state goes to S_DROP. It goes to S_IDLE instead if that byte is rx_eof.
  - Ethernet padding after the payload is never forwarded.
- Boundary conditions:
  - rx_eof in S_HDR: drop_count++, go to S_IDLE.
  - rx_eof (or rx_err) in S_PAY before the last payload byte: out_abort pulses, drop_count++, go to S_IDLE.
  - rx_err on an eof that coincides with the out_last byte: out_last is suppressed, out_abort pulses, drop_count++, and no send_echo is issued.
  - rx_sof in any non-idle state: the current frame is abandoned and parsing restarts at byte 0. If the frame was in S_PAY, out_abort pulses and drop_count++.
- Metadata outputs change only at the byte-41 accept. They are stable from send_echo until the next accepted header.

## Timing
- Reset values: every output and counter is 0, and the state is S_IDLE.
- Latency: out_payload, out_valid, out_last and out_abort are registered, one cycle after the corresponding rx byte.
- send_echo follows the cycle in which out_last is high.
- No backpressure: the RMII rate is at most 1 byte per 4 cycles, and downstream accepts every byte.
- rx_valid gaps of any length are legal in every state. Counters advance only on rx_valid.
- Reset asserted mid-frame clears all state immediately. No out_abort is issued.

## Structure
- Use the shared eth_defs.vh for FPGA_MAC, FPGA_IP and UDP_LISTEN_PORT.
- Add to eth_defs.vh: ETHERTYPE_IPV4 (16'h0800), IP_PROTO_UDP (8'h11), and the header byte offsets (ETH_HDR_LEN=42, OFF_UDP_LEN=38, and so on).
- Single module, no sub-module. The per-byte compare is a case on hdr_idx.

## Test plan
- Broadcast-MAC frame to FPGA_IP, port UDP_LISTEN_PORT, payload "ping" (udp_len=12): out_valid for 4 bytes, out_last on 'g', send_echo the next cycle, src_* equal the sent fields, pkt_count=1.
- Same datagram with 14 bytes of Ethernet padding: only 4 bytes are forwarded and padding is ignored.
- Wrong destination IP, wrong port, protocol 0x06 and IHL 0x46, one frame each: no out_valid, drop_count=4, src_* unchanged.
- Payload of 300 bytes (MAX_PAYLOAD=256): dropped at byte 41. A 256-byte payload is forwarded completely.
- rx_eof with rx_err at payload byte 2 of 10: out_abort pulse, no out_last, no send_echo.
- rx_sof mid-payload followed by a valid frame: out_abort, drop_count++, then the new frame is accepted normally.
- rst_n asserted mid-header: all outputs 0. The next frame is accepted normally.

Source files
------------

// File: rtl/udp_rx_parse_pkg.sv
// Shared Ethernet/IPv4/UDP definitions for the receive parser: local addressing,
// protocol constants and byte offsets into the 42-byte header.
package udp_rx_parse_pkg;

    localparam logic [47:0] FPGA_MAC        = 48'h02_12_34_56_78_9A;
    localparam logic [31:0] FPGA_IP         = 32'hC0A8_0164;
    localparam logic [15:0] UDP_LISTEN_PORT = 16'd5000;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    localparam logic [5:0] OFF_DST_MAC   = 6'd0;
    localparam logic [5:0] OFF_SRC_MAC   = 6'd6;
    localparam logic [5:0] OFF_ETHERTYPE = 6'd12;
    localparam logic [5:0] OFF_IP_VER    = 6'd14;
    localparam logic [5:0] OFF_IP_LEN    = 6'd16;
    localparam logic [5:0] OFF_IP_FLAGS  = 6'd20;
    localparam logic [5:0] OFF_IP_PROTO  = 6'd23;
    localparam logic [5:0] OFF_SRC_IP    = 6'd26;
    localparam logic [5:0] OFF_DST_IP    = 6'd30;
    localparam logic [5:0] OFF_SRC_PORT  = 6'd34;
    localparam logic [5:0] OFF_DST_PORT  = 6'd36;
    localparam logic [5:0] OFF_UDP_LEN   = 6'd38;
    localparam logic [5:0] ETH_HDR_LEN   = 6'd42;
    localparam logic [5:0] HDR_LAST      = ETH_HDR_LEN - 6'd1;

    typedef enum logic [1:0] {StIdle, StHdr, StPay, StDrop} state_e;

    // Byte i (0 = most significant) of an n-byte big-endian field held in v.
    function automatic logic [7:0] field_byte(logic [47:0] v, int unsigned n, int unsigned i);
        return v[8*(n-1-i) +: 8];
    endfunction

endpackage

// File: rtl/udp_rx_parse.sv
// Parses Ethernet/IPv4/UDP headers from the RX MAC byte stream, filters on local
// MAC/IP/port and forwards the UDP payload with reply addressing for the echo path.
module udp_rx_parse
    import udp_rx_parse_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 256
) (
    input  logic        clk50,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_sof,
    input  logic        rx_eof,
    input  logic        rx_err,
    output logic [7:0]  out_payload,
    output logic        out_valid,
    output logic        out_last,
    output logic        out_abort,
    output logic        send_echo,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [15:0] pkt_count,
    output logic [15:0] drop_count
);

    localparam logic [15:0] MAX_UDP_LEN = 16'(MAX_PAYLOAD + 8);

    state_e      state_q, state_d;
    logic [5:0]  hdr_idx_q, hdr_idx_d;
    logic        bad_q, bad_d;
    logic        uc_mis_q, uc_mis_d;
    logic        bc_mis_q, bc_mis_d;
    logic [47:0] sh_mac_q, sh_mac_d;
    logic [31:0] sh_ip_q, sh_ip_d;
    logic [15:0] sh_sport_q, sh_sport_d;
    logic [15:0] sh_dport_q, sh_dport_d;
    logic [15:0] ip_len_q, ip_len_d;
    logic [15:0] udp_len_q, udp_len_d;
    logic [15:0] pay_rem_q, pay_rem_d;
    logic [7:0]  out_payload_q, out_payload_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        out_abort_q, out_abort_d;
    logic        send_echo_q;
    logic [47:0] src_mac_q, src_mac_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [15:0] src_port_q, src_port_d;
    logic [15:0] dst_port_q, dst_port_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic [15:0] drop_count_q, drop_count_d;

    logic [5:0]  idx;
    logic        byte_bad, uc_mis, bc_mis;
    logic        hdr_bad;
    logic [1:0]  drop_inc;

    // A start-of-frame byte is always header byte 0, whatever state we were in.
    assign idx = rx_sof ? OFF_DST_MAC : hdr_idx_q;

    always_comb begin
        byte_bad = 1'b0;
        uc_mis   = 1'b0;
        bc_mis   = 1'b0;
        case (idx) inside
            [OFF_DST_MAC:OFF_DST_MAC+6'd5]: begin
                uc_mis = rx_data != field_byte(FPGA_MAC, 6, 32'(idx - OFF_DST_MAC));
                bc_mis = rx_data != 8'hFF;
            end
            OFF_ETHERTYPE:        byte_bad = rx_data != ETHERTYPE_IPV4[15:8];
            OFF_ETHERTYPE + 6'd1: byte_bad = rx_data != ETHERTYPE_IPV4[7:0];
            OFF_IP_VER:           byte_bad = rx_data != IP_VER_IHL;
            OFF_IP_FLAGS:         byte_bad = (rx_data & 8'h3F) != 8'h00;
            OFF_IP_FLAGS + 6'd1:  byte_bad = rx_data != 8'h00;
            OFF_IP_PROTO:         byte_bad = rx_data != IP_PROTO_UDP;
            [OFF_DST_IP:OFF_DST_IP+6'd3]:
                byte_bad = rx_data != field_byte({16'h0, FPGA_IP}, 4, 32'(idx - OFF_DST_IP));
            OFF_DST_PORT:         byte_bad = rx_data != UDP_LISTEN_PORT[15:8];
            OFF_DST_PORT + 6'd1:  byte_bad = rx_data != UDP_LISTEN_PORT[7:0];
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        hdr_idx_d     = hdr_idx_q;
        bad_d         = bad_q;
        uc_mis_d      = uc_mis_q;
        bc_mis_d      = bc_mis_q;
        sh_mac_d      = sh_mac_q;
        sh_ip_d       = sh_ip_q;
        sh_sport_d    = sh_sport_q;
        sh_dport_d    = sh_dport_q;
        ip_len_d      = ip_len_q;
        udp_len_d     = udp_len_q;
        pay_rem_d     = pay_rem_q;
        out_payload_d = out_payload_q;
        out_valid_d   = 1'b0;
        out_last_d    = 1'b0;
        out_abort_d   = 1'b0;
        src_mac_d     = src_mac_q;
        src_ip_d      = src_ip_q;
        src_port_d    = src_port_q;
        dst_port_d    = dst_port_q;
        pkt_count_d   = pkt_count_q;
        hdr_bad       = 1'b0;
        drop_inc      = 2'd0;

        if (rx_valid) begin
            if (rx_sof && state_q == StPay) begin
                out_abort_d = 1'b1;
                drop_inc    = drop_inc + 2'd1;
            end

            if (rx_sof || state_q == StHdr) begin
                bad_d     = (rx_sof ? 1'b0 : bad_q) | byte_bad;
                uc_mis_d  = (rx_sof ? 1'b0 : uc_mis_q) | uc_mis;
                bc_mis_d  = (rx_sof ? 1'b0 : bc_mis_q) | bc_mis;
                hdr_idx_d = idx + 6'd1;
                state_d   = StHdr;

                case (idx) inside
                    [OFF_SRC_MAC:OFF_SRC_MAC+6'd5]:   sh_mac_d   = {sh_mac_q[39:0], rx_data};
                    [OFF_IP_LEN:OFF_IP_LEN+6'd1]:     ip_len_d   = {ip_len_q[7:0], rx_data};
                    [OFF_SRC_IP:OFF_SRC_IP+6'd3]:     sh_ip_d    = {sh_ip_q[23:0], rx_data};
                    [OFF_SRC_PORT:OFF_SRC_PORT+6'd1]: sh_sport_d = {sh_sport_q[7:0], rx_data};
                    [OFF_DST_PORT:OFF_DST_PORT+6'd1]: sh_dport_d = {sh_dport_q[7:0], rx_data};
                    [OFF_UDP_LEN:OFF_UDP_LEN+6'd1]:   udp_len_d  = {udp_len_q[7:0], rx_data};
                    default: ;
                endcase

                hdr_bad = bad_d || (uc_mis_d && bc_mis_d) || udp_len_q < 16'd9 ||
                          udp_len_q > MAX_UDP_LEN || ip_len_q != udp_len_q + 16'd20;

                if (rx_eof) begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = StIdle;
                end else if (idx == HDR_LAST) begin
                    if (hdr_bad) begin
                        drop_inc = drop_inc + 2'd1;
                        state_d  = StDrop;
                    end else begin
                        src_mac_d  = sh_mac_q;
                        src_ip_d   = sh_ip_q;
                        src_port_d = sh_sport_q;
                        dst_port_d = sh_dport_q;
                        pay_rem_d  = udp_len_q - 16'd8;
                        state_d    = StPay;
                    end
                end
            end else begin
                case (state_q)
                    StPay: begin
                        if (rx_err || (rx_eof && pay_rem_q != 16'd1)) begin
                            out_abort_d = 1'b1;
                            drop_inc    = 2'd1;
                            state_d     = StIdle;
                        end else begin
                            out_payload_d = rx_data;
                            out_valid_d   = 1'b1;
                            pay_rem_d     = pay_rem_q - 16'd1;
                            if (pay_rem_q == 16'd1) begin
                                out_last_d  = 1'b1;
                                pkt_count_d = pkt_count_q + 16'd1;
                                state_d     = rx_eof ? StIdle : StDrop;
                            end
                        end
                    end
                    StDrop: if (rx_eof) state_d = StIdle;
                    default: ;
                endcase
            end
        end

        drop_count_d = drop_count_q + {14'd0, drop_inc};
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            hdr_idx_q     <= '0;
            bad_q         <= 1'b0;
            uc_mis_q      <= 1'b0;
            bc_mis_q      <= 1'b0;
            sh_mac_q      <= '0;
            sh_ip_q       <= '0;
            sh_sport_q    <= '0;
            sh_dport_q    <= '0;
            ip_len_q      <= '0;
            udp_len_q     <= '0;
            pay_rem_q     <= '0;
            out_payload_q <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_abort_q   <= 1'b0;
            send_echo_q   <= 1'b0;
            src_mac_q     <= '0;
            src_ip_q      <= '0;
            src_port_q    <= '0;
            dst_port_q    <= '0;
            pkt_count_q   <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            hdr_idx_q     <= hdr_idx_d;
            bad_q         <= bad_d;
            uc_mis_q      <= uc_mis_d;
            bc_mis_q      <= bc_mis_d;
            sh_mac_q      <= sh_mac_d;
            sh_ip_q       <= sh_ip_d;
            sh_sport_q    <= sh_sport_d;
            sh_dport_q    <= sh_dport_d;
            ip_len_q      <= ip_len_d;
            udp_len_q     <= udp_len_d;
            pay_rem_q     <= pay_rem_d;
            out_payload_q <= out_payload_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_abort_q   <= out_abort_d;
            send_echo_q   <= out_last_q;
            src_mac_q     <= src_mac_d;
            src_ip_q      <= src_ip_d;
            src_port_q    <= src_port_d;
            dst_port_q    <= dst_port_d;
            pkt_count_q   <= pkt_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign out_payload = out_payload_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_abort   = out_abort_q;
    assign send_echo   = send_echo_q;
    assign src_mac     = src_mac_q;
    assign src_ip      = src_ip_q;
    assign src_port    = src_port_q;
    assign dst_port    = dst_port_q;
    assign pkt_count   = pkt_count_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_udp_rx_parse.sv
// Directed bench for udp_rx_parse: builds frames byte by byte and checks the
// forwarded payload, pulses, captured addressing and counters.
module tb_udp_rx_parse;

    localparam logic [47:0] MY_MAC    = 48'h02_12_34_56_78_9A;
    localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] MY_IP     = 32'hC0A8_0164;
    localparam logic [15:0] MY_PORT   = 16'd5000;
    localparam logic [47:0] PEER_MAC  = 48'h00_1B_21_AA_BB_CC;
    localparam logic [47:0] OTHER_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] PEER_IP   = 32'hC0A8_0101;
    localparam logic [15:0] PEER_PORT = 16'hC351;
    localparam logic [31:0] PING      = 32'h70696E67;

    logic        clk50 = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0, rx_err = 1'b0;
    logic [7:0]  out_payload;
    logic        out_valid, out_last, out_abort, send_echo;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port, dst_port, pkt_count, drop_count;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int n_last = 0, n_abort = 0, n_echo = 0, n_echo_ok = 0;
    logic       prev_last = 1'b0;
    logic [7:0] last_byte = 8'h00;
    logic [7:0] got[$];
    logic [7:0] frm[$];

    udp_rx_parse #(.MAX_PAYLOAD(256)) dut (
        .clk50(clk50), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err),
        .out_payload(out_payload), .out_valid(out_valid), .out_last(out_last),
        .out_abort(out_abort), .send_echo(send_echo), .src_mac(src_mac), .src_ip(src_ip),
        .src_port(src_port), .dst_port(dst_port), .pkt_count(pkt_count),
        .drop_count(drop_count)
    );

    always #10 clk50 = ~clk50;

    always @(negedge clk50) begin
        if (out_valid) got.push_back(out_payload);
        if (out_last) begin
            n_last++;
            last_byte = out_payload;
        end
        if (out_abort) n_abort++;
        if (send_echo) begin
            n_echo++;
            if (prev_last) n_echo_ok++;
        end
        prev_last = out_last;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic push16(input logic [15:0] v);
        frm.push_back(v[15:8]);
        frm.push_back(v[7:0]);
    endtask

    task automatic build(input logic [47:0] dmac, input logic [47:0] smac,
                         input logic [31:0] dip, input logic [15:0] sport,
                         input logic [15:0] dport, input logic [7:0] ver,
                         input logic [7:0] proto, input int plen, input int pad,
                         input bit ping);
        logic [15:0] ulen, ilen;
        logic [31:0] pw;
        ulen = 16'(plen + 8);
        ilen = ulen + 16'd20;
        pw   = PING;
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(smac[8*i +: 8]);
        push16(16'h0800);
        frm.push_back(ver);
        frm.push_back(8'h00);
        push16(ilen);
        push16(16'h0001);
        push16(16'h4000);
        frm.push_back(8'h40);
        frm.push_back(proto);
        push16(16'h0000);
        push16(PEER_IP[31:16]);
        push16(PEER_IP[15:0]);
        push16(dip[31:16]);
        push16(dip[15:0]);
        push16(sport);
        push16(dport);
        push16(ulen);
        push16(16'h0000);
        for (int i = 0; i < plen; i++) frm.push_back(ping ? pw[8*(3-i) +: 8] : 8'(i*7+3));
        for (int i = 0; i < pad; i++) frm.push_back(8'h00);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof,
                             input logic err);
        @(negedge clk50);
        rx_data = d; rx_valid = 1'b1; rx_sof = sof; rx_eof = eof; rx_err = err;
        @(negedge clk50);
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
        repeat (2) @(negedge clk50);
    endtask

    task automatic send(input int n, input bit eof_end, input bit err_end);
        for (int i = 0; i < n; i++)
            send_byte(frm[i], i == 0, eof_end && i == n-1, err_end && i == n-1);
        repeat (4) @(negedge clk50);
    endtask

    initial begin
        int mism;
        repeat (3) @(negedge clk50);
        rst_n = 1'b1;
        @(negedge clk50);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_abort", 64'(out_abort), 64'd0);
        check("rst_echo", 64'(send_echo), 64'd0);
        check("rst_counts", 64'({pkt_count, drop_count}), 64'd0);
        check("rst_meta", 64'({src_mac, src_port}), 64'd0);
        check("rst_ipport", 64'({src_ip, dst_port}), 64'd0);

        // broadcast "ping"
        build(BCAST, PEER_MAC, MY_IP, PEER_PORT, MY_PORT, 8'h45, 8'h11, 4, 0, 1'b1);
        send(46, 1'b1, 1'b0);
        check("ping_nbytes", 64'(got.size()), 64'd4);
        check("ping_data", 64'({got[0], got[1], got[2], got[3]}), 64'(PING));
        check("ping_lastbyte", 64'(last_byte), 64'h67);
        check("ping_nlast", 64'(n_last), 64'd1);
        check("ping_necho", 64'(n_echo), 64'd1);
        check("ping_echo_after_last", 64'(n_echo_ok), 64'd1);
        check("ping_src_mac", 64'(src_mac), 64'(PEER_MAC));
        check("ping_src_ip", 64'(src_ip), 64'(PEER_IP));
        check("ping_src_port", 64'(src_port), 64'(PEER_PORT));
        check("ping_dst_port", 64'(dst_port), 64'(MY_PORT));
        check("ping_pkt", 64'(pkt_count), 64'd1);
        check("ping_drop", 64'(drop_count), 64'd0);

        // unicast with 14 bytes of Ethernet padding
        build(MY_MAC, PEER_MAC, MY_IP, PEER_PORT, MY_PORT, 8'h45, 8'h11, 4, 14, 1'b1);
        send(60, 1'b1, 1'b0);
        check("pad_nbytes", 64'(got.size()), 64'd8);
        check("pad_data", 64'({got[4], got[5], got[6], got[7]}), 64'(PING));
        check("pad_pkt", 64'(pkt_count), 64'd2);
        check("pad_necho", 64'(n_echo), 64'd2);
        check("pad_drop", 64'(drop_count), 64'd0);

        // four rejected headers from a different sender
        build(MY_MAC, OTHER_MAC, 32'hC0A8_0165, 16'h1111, MY_PORT, 8'h45, 8'h11, 4, 0, 1'b1);
        send(46, 1'b1, 1'b0);
        build(MY_MAC, OTHER_MAC, MY_IP, 16'h1111, 16'd5001, 8'h45, 8'h11, 4, 0, 1'b1);
        send(46, 1'b1, 1'b0);
        build(MY_MAC, OTHER_MAC, MY_IP, 16'h1111, MY_PORT, 8'h45, 8'h06, 4, 0, 1'b1);
        send(46, 1'b1, 1'b0);
        build(MY_MAC, OTHER_MAC, MY_IP, 16'h1111, MY_PORT, 8'h46, 8'h11, 4, 0, 1'b1);
        send(46, 1'b1, 1'b0);
        check("rej_nbytes", 64'(got.size()), 64'd8);
        check("rej_drop", 64'(drop_count), 64'd4);
        check("rej_pkt", 64'(pkt_count), 64'd2);
        check("rej_src_mac", 64'(src_mac), 64'(PEER_MAC));
        check("rej_src_port", 64'(src_port), 64'(PEER_PORT));

        // oversize then maximum-size payload
        build(MY_MAC, PEER_MAC, MY_IP, PEER_PORT, MY_PORT, 8'h45, 8'h11, 300, 0, 1'b0);
        send(342, 1'b1, 1'b0);
        check("big_drop", 64'(drop_count), 64'd5);
        check("big_nbytes", 64'(got.size()), 64'd8);
        build(MY_MAC, PEER_MAC, MY_IP, PEER_PORT, MY_PORT, 8'h45, 8'h11, 256, 0, 1'b0);
        send(298, 1'b1, 1'b0);
        check("max_nbytes", 64'(got.size()), 64'd264);
        mism = 0;
        for (int i = 0; i < 256 && i + 8 < got.size(); i++)
            if (got[i+8] !== 8'(i*7+3)) mism++;
        check("max_data_mismatches", 64'(mism), 64'd0);
        check("max_lastbyte", 64'(last_byte), 64'h FC);
        check("max_pkt", 64'(pkt_count), 64'd3);

        // eof+err on the second of ten payload bytes
        build(MY_MAC, PEER_MAC, MY_IP, PEER_PORT, MY_PORT, 8'h45, 8'h11, 10, 0, 1'b0);
        send(44, 1'b1, 1'b1);
        check("err_nbytes", 64'(got.size()), 64'd265);
        check("err_nabort", 64'(n_abort), 64'd1);
        check("err_nlast", 64'(n_last), 64'd3);
        check("err_necho", 64'(n_echo), 64'd3);
        check("err_drop", 64'(drop_count), 64'd6);
        check("err_pkt", 64'(pkt_count), 64'd3);

        // new sof in the middle of a payload, then a good frame
        send(47, 1'b0, 1'b0);
        build(MY_MAC, PEER_MAC, MY_IP, 16'h1234, MY_PORT, 8'h45, 8'h11, 4, 0, 1'b1);
        send(46, 1'b1, 1'b0);
        check("sof_nabort", 64'(n_abort), 64'd2);
        check("sof_drop", 64'(drop_count), 64'd7);
        check("sof_nbytes", 64'(got.size()), 64'd274);
        check("sof_pkt", 64'(pkt_count), 64'd4);
        check("sof_src_port", 64'(src_port), 64'h1234);
        check("sof_necho", 64'(n_echo), 64'd4);

        // reset in the middle of a header
        build(MY_MAC, PEER_MAC, MY_IP, PEER_PORT, MY_PORT, 8'h45, 8'h11, 4, 0, 1'b1);
        for (int i = 0; i < 20; i++) send_byte(frm[i], i == 0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("mrst_counts", 64'({pkt_count, drop_count}), 64'd0);
        check("mrst_src_mac", 64'(src_mac), 64'd0);
        check("mrst_ipport", 64'({src_ip, src_port}), 64'd0);
        check("mrst_outs", 64'({out_valid, out_last, out_abort, send_echo}), 64'd0);
        repeat (2) @(negedge clk50);
        rst_n = 1'b1;
        send(46, 1'b1, 1'b0);
        check("mrst_pkt", 64'(pkt_count), 64'd1);
        check("mrst_drop", 64'(drop_count), 64'd0);
        check("mrst_src_port", 64'(src_port), 64'(PEER_PORT));
        check("mrst_necho", 64'(n_echo), 64'd5);
        check("mrst_nabort", 64'(n_abort), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
